// File: rtl/seven_seg_scan.sv
// Four-digit scan driver: frame-latched inputs, anti-ghost blank phase, optional PWM dimming (SEG_SCAN_DIM_EN).
// Latency: outputs registered one cycle behind the scan counters; free-running, no backpressure.
module seven_seg_scan #(
  parameter int PHASE_LEN = 3125
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] seg_in_1,
  input  logic [7:0] seg_in_2,
  input  logic [7:0] seg_in_3,
  input  logic [7:0] seg_in_4,
  input  logic [3:0] digit_en,
  input  logic [2:0] brightness,
  output logic [7:0] seg_out,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int CW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(PHASE_LEN - 1);

  logic [CW-1:0] cyc;
  logic [2:0]    phase;
  logic [1:0]    slot;
  logic [7:0]    seg_sh [4];
  logic [3:0]    digit_en_sh;
  logic [2:0]    bright_eff;
  logic          bnd_q;
  logic          cyc_last;
  logic          boundary;
  logic          lit;

  assign cyc_last = (cyc == CYC_LAST);
  assign boundary = cyc_last && (phase == 3'd7) && (slot == 2'd3);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc   <= '0;
      phase <= '0;
      slot  <= '0;
    end else if (cyc_last) begin
      cyc   <= '0;
      phase <= phase + 3'd1;
      if (phase == 3'd7) begin
        slot <= slot + 2'd1;
      end
    end else begin
      cyc <= cyc + CW'(1);
    end
  end

  // Inputs are sampled only on the frame boundary so a frame never shows a mix of old and new data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg_sh      <= '{default: 8'hFF};
      digit_en_sh <= 4'h0;
    end else if (boundary) begin
      seg_sh[0]   <= seg_in_1;
      seg_sh[1]   <= seg_in_2;
      seg_sh[2]   <= seg_in_3;
      seg_sh[3]   <= seg_in_4;
      digit_en_sh <= digit_en;
    end
  end

`ifdef SEG_SCAN_DIM_EN
  logic [2:0] bright_sh;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bright_sh <= 3'd7;
    end else if (boundary) begin
      bright_sh <= brightness;
    end
  end

  assign bright_eff = bright_sh;
`else
  logic unused_bright;

  assign unused_bright = ^brightness;
  assign bright_eff    = 3'd7;
`endif

  // Phase 0 of every slot stays dark so the anode switch never overlaps the previous digit's segments.
  assign lit = digit_en_sh[slot] && (phase != 3'd0) && (phase <= bright_eff);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg_out    <= 8'hFF;
      an         <= 4'hF;
      frame_tick <= 1'b0;
      bnd_q      <= 1'b0;
    end else begin
      bnd_q      <= boundary;
      frame_tick <= bnd_q;
      an         <= lit ? ~(4'b0001 << slot) : 4'hF;
      seg_out    <= lit ? seg_sh[slot] : 8'hFF;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan at PHASE_LEN=2: frame-position reference model plus directed literal checks.
module tb_seven_seg_scan;

  localparam int PL    = 2;
  localparam int SLOT  = 8 * PL;
  localparam int FRAME = 32 * PL;
`ifdef SEG_SCAN_DIM_EN
  localparam bit DIM = 1'b1;
`else
  localparam bit DIM = 1'b0;
`endif

  logic       clk  = 1'b0;
  logic       rstn = 1'b1;
  logic [7:0] seg_in_1, seg_in_2, seg_in_3, seg_in_4;
  logic [3:0] digit_en;
  logic [2:0] brightness;
  logic [7:0] seg_out;
  logic [3:0] an;
  logic       frame_tick;

  int checks = 0;
  int fails  = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  seven_seg_scan #(.PHASE_LEN(PL)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .seg_in_1   (seg_in_1),
    .seg_in_2   (seg_in_2),
    .seg_in_3   (seg_in_3),
    .seg_in_4   (seg_in_4),
    .digit_en   (digit_en),
    .brightness (brightness),
    .seg_out    (seg_out),
    .an         (an),
    .frame_tick (frame_tick)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: position in frame derived from edges since reset release.
  int unsigned edges = 0;
  logic [7:0]  m_seg [4] = '{default: 8'hFF};
  logic [3:0]  m_en = 4'h0;
  logic [2:0]  m_br = 3'd7;
  logic [7:0]  exp_seg = 8'hFF;
  logic [3:0]  exp_an = 4'hF;
  logic        exp_tick = 1'b0;
  int          mk, ms, mp;
  bit          mlit;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edges    = 0;
      m_seg    = '{default: 8'hFF};
      m_en     = 4'h0;
      m_br     = 3'd7;
      exp_seg  = 8'hFF;
      exp_an   = 4'hF;
      exp_tick = 1'b0;
    end else begin
      mk   = int'(edges % FRAME);
      ms   = mk / SLOT;
      mp   = (mk % SLOT) / PL;
      mlit = m_en[ms] && (mp >= 1) && (mp <= (DIM ? int'(m_br) : 7));
      exp_an   = mlit ? ~(4'b0001 << ms) : 4'hF;
      exp_seg  = mlit ? m_seg[ms] : 8'hFF;
      exp_tick = (mk == 0) && (edges >= FRAME);
      if (mk == FRAME - 1) begin
        m_seg[0] = seg_in_1;
        m_seg[1] = seg_in_2;
        m_seg[2] = seg_in_3;
        m_seg[3] = seg_in_4;
        m_en     = digit_en;
        m_br     = brightness;
      end
      edges++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("seg_out", int'(seg_out), int'(exp_seg));
      check("an", int'(an), int'(exp_an));
      check("frame_tick", int'(frame_tick), int'(exp_tick));
    end
  end

  task automatic wait_tick(output int waited, output int lit_seen);
    waited   = 0;
    lit_seen = 0;
    for (int i = 1; i <= 4 * FRAME; i++) begin
      @(negedge clk);
      if (an != 4'hF) lit_seen++;
      if (frame_tick) begin
        waited = i;
        return;
      end
    end
    check("tick_timeout", 0, 1);
  endtask

  // Samples one frame starting at the current (tick) cycle; optionally changes seg_in_2 mid-frame.
  task automatic measure(input logic [3:0] an_sel, input logic [7:0] seg_want,
                         input int chg_at, input logic [7:0] chg_val,
                         output int lit_c, output int sel_c, output int other_c, output int ticks);
    lit_c = 0; sel_c = 0; other_c = 0; ticks = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      if (an != 4'hF) lit_c++;
      if (an == an_sel && seg_out == seg_want) sel_c++;
      if (an != 4'hF && an != 4'hE && an != 4'hB) other_c++;
      if (frame_tick) ticks++;
      if (i == chg_at) seg_in_2 = chg_val;
    end
  endtask

  task automatic settle();
    int w, l;
    wait_tick(w, l);
    wait_tick(w, l);
  endtask

  int n, lit_cnt, sel_cnt, oth_cnt, tk_cnt;

  initial begin
    seg_in_1 = 8'hF9; seg_in_2 = 8'hA4; seg_in_3 = 8'hB0; seg_in_4 = 8'h99;
    digit_en = 4'hF; brightness = 3'd7;
    #1 rstn = 1'b0;
    #10;
    check("reset_seg_out", int'(seg_out), 8'hFF);
    check("reset_an", int'(an), 4'hF);
    check("reset_tick", int'(frame_tick), 0);
    @(negedge clk);
    rstn   = 1'b1;
    chk_on = 1'b1;

    // First frame after reset is blank; tick marks state 0 of frame two.
    wait_tick(n, lit_cnt);
    check("first_tick_cycle", n, FRAME + 1);
    check("first_frame_blank", lit_cnt, 0);
    measure(4'hE, 8'hF9, -1, 8'h00, lit_cnt, sel_cnt, oth_cnt, tk_cnt);
    check("full_lit_cycles", lit_cnt, 56);
    check("slot0_f9_cycles", sel_cnt, 14);
    check("ticks_per_frame", tk_cnt, 1);

    brightness = 3'd3;
    settle();
    measure(4'hE, 8'hF9, -1, 8'h00, lit_cnt, sel_cnt, oth_cnt, tk_cnt);
    check("bright3_lit", lit_cnt, DIM ? 24 : 56);
    check("bright3_slot0", sel_cnt, DIM ? 6 : 14);

    brightness = 3'd0;
    settle();
    measure(4'hE, 8'hF9, -1, 8'h00, lit_cnt, sel_cnt, oth_cnt, tk_cnt);
    check("bright0_lit", lit_cnt, DIM ? 0 : 56);

    brightness = 3'd7;
    digit_en   = 4'b0101;
    settle();
    measure(4'hB, 8'hB0, -1, 8'h00, lit_cnt, sel_cnt, oth_cnt, tk_cnt);
    check("en0101_lit", lit_cnt, 28);
    check("en0101_slot2_b0", sel_cnt, 14);
    check("en0101_bad_an", oth_cnt, 0);
    wait_tick(n, lit_cnt);
    check("en0101_period", n, 1);

    digit_en = 4'hF;
    settle();
    measure(4'hD, 8'hA4, 20, 8'h82, lit_cnt, sel_cnt, oth_cnt, tk_cnt);
    check("tear_cur_a4", sel_cnt, 14);
    wait_tick(n, lit_cnt);
    measure(4'hD, 8'h82, 62, 8'hC0, lit_cnt, sel_cnt, oth_cnt, tk_cnt);
    check("tear_next_82", sel_cnt, 14);
    wait_tick(n, lit_cnt);
    measure(4'hD, 8'hC0, -1, 8'h00, lit_cnt, sel_cnt, oth_cnt, tk_cnt);
    check("boundary_capture_c0", sel_cnt, 14);

    // Asynchronous reset pulse in slot 2 while a digit is lit.
    wait_tick(n, lit_cnt);
    repeat (40) @(negedge clk);
    check("pre_reset_an", int'(an), 4'hB);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_an", int'(an), 4'hF);
    check("async_rst_seg", int'(seg_out), 8'hFF);
    check("async_rst_tick", int'(frame_tick), 0);
    rstn = 1'b1;
    wait_tick(n, lit_cnt);
    check("post_reset_tick_cycle", n, FRAME + 1);
    check("post_reset_blank", lit_cnt, 0);

    // Random input churn, checked every cycle by the reference model.
    for (int i = 0; i < 12 * FRAME; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(5))
          0: seg_in_1 = 8'($urandom);
          1: seg_in_2 = 8'($urandom);
          2: seg_in_3 = 8'($urandom);
          3: seg_in_4 = 8'($urandom);
          4: digit_en = 4'($urandom);
          default: brightness = 3'($urandom);
        endcase
      end
    end

    repeat (2) @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
